sync_fifo_thr: RTL and testbench



---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_mem.sv | 43 ++++
 rtl/sync_fifo_thr.sv | 90 +++++++++
 tb/tb_sync_fifo_thr.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO package: default widths, pointer type and parameter legality check.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;

  typedef logic [ADDR_WIDTH_DEF:0] ptr_t;

  function automatic bit thr_ok(input int aw, input int ae_lvl, input int af_lvl);
    int depth;
    depth = 1 << aw;
    return (aw >= 1) && (ae_lvl >= 0) && (ae_lvl < af_lvl) && (af_lvl <= depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage, one synchronous write port and one read port.
// Read port is combinational when FIFO_FWFT_EN is defined, registered otherwise.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
`ifndef FIFO_FWFT_EN
  input  logic                  rst_n,
  input  logic                  re,
`endif
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef FIFO_FWFT_EN
  assign rdata = mem[raddr];
`else
  logic [DATA_WIDTH-1:0] rdata_p1;

  // read stage: head word captured on an accepted read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_p1 <= '0;
    else if (re) rdata_p1 <= mem[raddr];
  end

  assign rdata = rdata_p1;
`endif

endmodule

// File: rtl/sync_fifo_thr.sv
// Single-clock FIFO with almost-full/almost-empty thresholds, occupancy and sticky errors.
// Define FIFO_FWFT_EN for first-word fall-through reads; default is registered rdata.
module sync_fifo_thr
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int AFULL_LVL  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wfull,
  output logic                  walmost_full,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam logic [ADDR_WIDTH:0] AFULL_C  = AFULL_LVL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = AEMPTY_LVL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = 1;

  if (!thr_ok(ADDR_WIDTH, AEMPTY_LVL, AFULL_LVL)) begin : g_bad_params
    $error("sync_fifo_thr: illegal ADDR_WIDTH/AEMPTY_LVL/AFULL_LVL combination");
  end

  logic [ADDR_WIDTH:0] wptr;
  logic [ADDR_WIDTH:0] rptr;
  logic                wr_acc;
  logic                rd_acc;

  // Flags decode from registered pointers only; the MSB distinguishes full from empty.
  assign count         = wptr - rptr;
  assign rempty        = (wptr == rptr);
  assign wfull         = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                         (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
  assign walmost_full  = (count >= AFULL_C);
  assign ralmost_empty = (count <= AEMPTY_C);

  assign wr_acc = winc && !wfull;
  assign rd_acc = rinc && !rempty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + PTR_ONE;
      if (rd_acc) rptr <= rptr + PTR_ONE;
    end
  end

  // A new error event takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && wfull) overflow <= 1'b1;
      else if (clr_err)  overflow <= 1'b0;
      if (rinc && rempty) underflow <= 1'b1;
      else if (clr_err)   underflow <= 1'b0;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
`ifndef FIFO_FWFT_EN
    .rst_n (rst_n),
    .re    (rd_acc),
`endif
    .we    (wr_acc),
    .waddr (wptr[ADDR_WIDTH-1:0]),
    .wdata (wdata),
    .raddr (rptr[ADDR_WIDTH-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_sync_fifo_thr.sv
// Directed bench for sync_fifo_thr: vector table plus hand-written wrap, corner and async-reset sequences.
module tb_sync_fifo_thr;

  localparam int DW = 8;
  localparam int AW = 4;
`ifdef FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          winc;
  logic [DW-1:0] wdata;
  logic          wfull;
  logic          walmost_full;
  logic          rinc;
  logic [DW-1:0] rdata;
  logic          rempty;
  logic          ralmost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
  logic          clr_err;

  always #5 clk = ~clk;

  sync_fifo_thr #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AFULL_LVL  (14),
    .AEMPTY_LVL (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .winc          (winc),
    .wdata         (wdata),
    .wfull         (wfull),
    .walmost_full  (walmost_full),
    .rinc          (rinc),
    .rdata         (rdata),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .count         (count),
    .overflow      (overflow),
    .underflow     (underflow),
    .clr_err       (clr_err)
  );

  // flag order: {wfull, walmost_full, rempty, ralmost_empty, overflow, underflow}
  typedef struct {
    logic          winc;
    logic          rinc;
    logic          clr;
    logic [DW-1:0] wdata;
    logic [AW:0]   cnt;
    logic [5:0]    flg;
    logic          chk_rd;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t vq[$];
  int   nvec = 0;
  int   nbad = 0;

  function automatic logic [5:0] flags(bit wf, bit af, bit re, bit ae, bit ov, bit un);
    return {wf, af, re, ae, ov, un};
  endfunction

  function automatic vec_t mkv(bit w, bit r, bit c, int d, int cnt, logic [5:0] flg, bit chk, int rd);
    vec_t v;
    v.winc = w; v.rinc = r; v.clr = c;
    v.wdata = d[DW-1:0]; v.cnt = cnt[AW:0]; v.flg = flg;
    v.chk_rd = chk; v.rd = rd[DW-1:0];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit w, bit r, bit c, int d);
    winc = w; rinc = r; clr_err = c; wdata = d[DW-1:0];
  endtask

  task automatic check_state(string name, int cnt, logic [5:0] flg);
    logic [5:0] act;
    act = {wfull, walmost_full, rempty, ralmost_empty, overflow, underflow};
    nvec++;
    if (count !== cnt[AW:0]) begin
      nbad++;
      $display("FAIL %s count: got %0d expected %0d", name, count, cnt);
    end
    nvec++;
    if (act !== flg) begin
      nbad++;
      $display("FAIL %s flags{wf,af,re,ae,ov,un}: got %b expected %b", name, act, flg);
    end
  endtask

  task automatic check_rd(string name, int exp);
    nvec++;
    if (rdata !== exp[DW-1:0]) begin
      nbad++;
      $display("FAIL %s rdata: got %02h expected %02h", name, rdata, exp[DW-1:0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0);

    // ---- vector table: reset/idle, fill, overflow, drain, underflow, clear ----
    vq.push_back(mkv(0, 0, 0, 0, 0, flags(0, 0, 1, 1, 0, 0), !FWFT, 0));
    for (int i = 0; i < 16; i++)
      vq.push_back(mkv(1, 0, 0, i, i + 1, flags(i == 15, (i + 1) >= 14, 0, (i + 1) <= 2, 0, 0), 0, 0));
    vq.push_back(mkv(1, 0, 0, 8'hEE, 16, flags(1, 1, 0, 0, 1, 0), 1, 0));
    for (int i = 0; i < 16; i++)
      vq.push_back(mkv(0, 1, 0, 0, 15 - i, flags(0, (15 - i) >= 14, i == 15, (15 - i) <= 2, 1, 0),
                       FWFT ? (i < 15) : 1'b1, FWFT ? i + 1 : i));
    vq.push_back(mkv(0, 1, 0, 0, 0, flags(0, 0, 1, 1, 1, 1), 0, 0));
    vq.push_back(mkv(0, 1, 1, 0, 0, flags(0, 0, 1, 1, 0, 1), 0, 0));
    vq.push_back(mkv(0, 0, 1, 0, 0, flags(0, 0, 1, 1, 0, 0), 0, 0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    foreach (vq[k]) begin
      drive(vq[k].winc, vq[k].rinc, vq[k].clr, vq[k].wdata);
      step();
      check_state($sformatf("vec%0d", k), vq[k].cnt, vq[k].flg);
      if (vq[k].chk_rd) check_rd($sformatf("vec%0d", k), vq[k].rd);
    end
    drive(0, 0, 0, 0);

    // ---- steady state at count 8 with simultaneous read/write across wraps ----
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, 0, 8'h40 + k);
      step();
    end
    drive(0, 0, 0, 0);
    check_state("hold_fill", 8, flags(0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 40; k++) begin
      drive(1, 1, 0, 8'h48 + k);
      step();
      check_state($sformatf("hold%0d", k), 8, flags(0, 0, 0, 0, 0, 0));
      check_rd($sformatf("hold%0d", k), FWFT ? 8'h41 + k : 8'h40 + k);
    end
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 0, 0);
      step();
      if (!FWFT)  check_rd($sformatf("hold_drain%0d", k), 8'h68 + k);
      else if (k < 7) check_rd($sformatf("hold_drain%0d", k), 8'h69 + k);
    end
    drive(0, 0, 0, 0);
    check_state("hold_empty", 0, flags(0, 0, 1, 1, 0, 0));

    // ---- full + simultaneous, then empty + simultaneous ----
    for (int k = 0; k < 16; k++) begin
      drive(1, 0, 0, 8'h80 + k);
      step();
    end
    check_state("full_pre", 16, flags(1, 1, 0, 0, 0, 0));
    drive(1, 1, 0, 8'hFF);
    step();
    check_state("full_wr_rd", 15, flags(0, 1, 0, 0, 1, 0));
    check_rd("full_wr_rd", FWFT ? 8'h81 : 8'h80);
    for (int k = 0; k < 15; k++) begin
      drive(0, 1, 0, 0);
      step();
    end
    check_state("drain15", 0, flags(0, 0, 1, 1, 1, 0));
    if (!FWFT) check_rd("drain15", 8'h8F);
    drive(1, 1, 0, 8'hAA);
    step();
    check_state("empty_wr_rd", 1, flags(0, 0, 0, 1, 1, 1));
    check_rd("empty_wr_rd", FWFT ? 8'hAA : 8'h8F);
    drive(0, 1, 0, 0);
    step();
    check_state("empty_pop", 0, flags(0, 0, 1, 1, 1, 1));
    if (!FWFT) check_rd("empty_pop", 8'hAA);

    // ---- asynchronous reset mid-burst at count 5 ----
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 8'h30 + k);
      step();
    end
    check_state("burst5", 5, flags(0, 0, 0, 0, 1, 1));
    wdata = 8'h35;
    #3;
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 0, flags(0, 0, 1, 1, 0, 0));
    if (!FWFT) check_rd("async_rst", 0);
    wdata = 8'hC5;
    #1;
    rst_n = 1'b1;
    step();
    check_state("post_rst_wr", 1, flags(0, 0, 0, 1, 0, 0));
    if (FWFT) check_rd("post_rst_wr", 8'hC5);
    drive(0, 1, 0, 0);
    step();
    check_state("post_rst_rd", 0, flags(0, 0, 1, 1, 0, 0));
    if (!FWFT) check_rd("post_rst_rd", 8'hC5);
    drive(0, 0, 0, 0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
